// File: rtl/seq_gen_pkg.sv
// Shared constants for the parametrised sequence generator: end-of-range mode
// encodings and default geometry.
package seq_gen_pkg;

   localparam logic [1:0] MODE_WRAP    = 2'b00;
   localparam logic [1:0] MODE_SAT     = 2'b01;
   localparam logic [1:0] MODE_BOUNCE  = 2'b10;
   localparam logic [1:0] MODE_ONESHOT = 2'b11;

   localparam int unsigned DEF_W   = 4;
   localparam int unsigned DEF_MOD = 16;
   localparam int unsigned DEF_OW  = 4;

endpackage

// File: rtl/seq_out_table.sv
// Output map of MOD entries, OW bits each: synchronous write, combinational
// read, identity contents after reset.
module seq_out_table
   import seq_gen_pkg::*;
#(
   parameter int unsigned W   = DEF_W,
   parameter int unsigned MOD = DEF_MOD,
   parameter int unsigned OW  = DEF_OW
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          we,
   input  logic [W-1:0]  waddr,
   input  logic [OW-1:0] wdat,
   input  logic [W-1:0]  raddr,
   output logic [OW-1:0] rdat
);

   logic [OW-1:0] tbl_q [MOD];

   // Reset takes precedence over a write on the same edge.
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < int'(MOD); i++) begin
            tbl_q[i] <= OW'(i);
         end
      end else if (we && (32'(waddr) < MOD)) begin
         tbl_q[waddr] <= wdat;
      end
   end

   always_comb begin
      rdat = '0;
      if (32'(raddr) < MOD) begin
         rdat = tbl_q[raddr];
      end
   end

endmodule

// File: rtl/seq_gen_fsm_param.sv
// Up/down modulo-MOD state counter with wrap/saturate/bounce/one-shot end
// handling, registered terminal-count pulse and a writable output map.
module seq_gen_fsm_param
   import seq_gen_pkg::*;
#(
   parameter int unsigned W   = DEF_W,
   parameter int unsigned MOD = DEF_MOD,
   parameter int unsigned OW  = DEF_OW
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          CE,
   input  logic          LOAD,
   input  logic [W-1:0]  DAT_I,
   input  logic          UP,
   input  logic [1:0]    MODE,
   input  logic          TBL_WE,
   input  logic [W-1:0]  TBL_ADDR,
   input  logic [OW-1:0] TBL_DAT,
   output logic [W-1:0]  CNT,
   output logic [OW-1:0] SEQ,
   output logic          TC,
   output logic          DIR,
   output logic          DONE
);

   localparam int unsigned TOP_I = MOD - 1;
   localparam logic [W:0]  TOP   = TOP_I[W:0];
   localparam logic [W:0]  ONE   = (W+1)'(1);

   logic [W-1:0] cnt_q, cnt_d;
   logic         dir_q, dir_d;
   logic         done_q, done_d;
   logic         tc_q, tc_d;

   logic         d_up, at_term, reach;
   logic [W:0]   cnt_x, step_x, hold_x, load_x, bounce_x;

   always_comb begin
      cnt_x    = {1'b0, cnt_q};
      d_up     = (MODE == MODE_BOUNCE) ? dir_q : UP;
      at_term  = d_up ? (cnt_x == TOP) : (cnt_x == '0);
      step_x   = d_up ? (cnt_x + ONE) : (cnt_x - ONE);
      hold_x   = at_term ? cnt_x : step_x;
      reach    = d_up ? (hold_x == TOP) : (hold_x == '0);
      load_x   = ({1'b0, DAT_I} > TOP) ? TOP : {1'b0, DAT_I};
      // A single-state range has nowhere to bounce to.
      bounce_x = (MOD == 1) ? '0 : (d_up ? (TOP - ONE) : ONE);

      cnt_d  = cnt_q;
      dir_d  = dir_q;
      done_d = done_q;
      tc_d   = 1'b0;

      if (LOAD) begin
         cnt_d  = load_x[W-1:0];
         dir_d  = UP;
         done_d = 1'b0;
      end else if (CE) begin
         unique case (MODE)
            MODE_WRAP: begin
               tc_d  = at_term;
               cnt_d = at_term ? (d_up ? '0 : TOP[W-1:0]) : step_x[W-1:0];
            end
            MODE_SAT: begin
               tc_d  = at_term;
               cnt_d = hold_x[W-1:0];
            end
            MODE_BOUNCE: begin
               tc_d  = at_term;
               cnt_d = at_term ? bounce_x[W-1:0] : step_x[W-1:0];
               if (at_term) dir_d = ~d_up;
            end
            MODE_ONESHOT: begin
               if (!done_q) begin
                  cnt_d  = hold_x[W-1:0];
                  done_d = reach;
                  tc_d   = reach;
               end
            end
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt_q  <= '0;
         dir_q  <= 1'b1;
         done_q <= 1'b0;
         tc_q   <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         dir_q  <= dir_d;
         done_q <= done_d;
         tc_q   <= tc_d;
      end
   end

   seq_out_table #(
      .W   (W),
      .MOD (MOD),
      .OW  (OW)
   ) u_table (
      .CLK   (CLK),
      .RST   (RST),
      .we    (TBL_WE),
      .waddr (TBL_ADDR),
      .wdat  (TBL_DAT),
      .raddr (cnt_q),
      .rdat  (SEQ)
   );

   assign CNT  = cnt_q;
   assign TC   = tc_q;
   assign DIR  = (MODE == MODE_BOUNCE) ? dir_q : UP;
   assign DONE = done_q;

endmodule

// File: tb/tb_seq_gen_fsm_param.sv
// Scoreboard bench: two instances (MOD=10 and MOD=16) share stimulus; expected
// post-edge outputs are queued at the driving edge and checked after the next CLK rise.
module tb_seq_gen_fsm_param;
   import seq_gen_pkg::*;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       CE = 1'b0, LOAD = 1'b0, UP = 1'b0, TBL_WE = 1'b0;
   logic [3:0] DAT_I = '0, TBL_ADDR = '0, TBL_DAT = '0;
   logic [1:0] MODE = MODE_WRAP;

   logic [3:0] a_cnt, a_seq, b_cnt, b_seq;
   logic       a_tc, a_dir, a_done, b_tc, b_dir, b_done;

   always #5 CLK = ~CLK;

   seq_gen_fsm_param #(.W(4), .MOD(10), .OW(4)) dut_a (
      .CLK(CLK), .RST(RST), .CE(CE), .LOAD(LOAD), .DAT_I(DAT_I), .UP(UP), .MODE(MODE),
      .TBL_WE(TBL_WE), .TBL_ADDR(TBL_ADDR), .TBL_DAT(TBL_DAT),
      .CNT(a_cnt), .SEQ(a_seq), .TC(a_tc), .DIR(a_dir), .DONE(a_done)
   );

   seq_gen_fsm_param #(.W(4), .MOD(16), .OW(4)) dut_b (
      .CLK(CLK), .RST(RST), .CE(CE), .LOAD(LOAD), .DAT_I(DAT_I), .UP(UP), .MODE(MODE),
      .TBL_WE(TBL_WE), .TBL_ADDR(TBL_ADDR), .TBL_DAT(TBL_DAT),
      .CNT(b_cnt), .SEQ(b_seq), .TC(b_tc), .DIR(b_dir), .DONE(b_done)
   );

   typedef struct {
      bit         on_b;
      string      name;
      logic [3:0] cnt;
      logic [3:0] seq;
      logic       tc;
      logic       dir;
      logic       done;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Monitor: drains everything queued for the edge that just happened.
   always begin : monitor
      exp_t       e;
      logic [3:0] c, s;
      logic       t, d, dn;
      @(posedge CLK);
      #1;
      while (sb_q.size() > 0) begin
         e  = sb_q.pop_front();
         c  = e.on_b ? b_cnt  : a_cnt;
         s  = e.on_b ? b_seq  : a_seq;
         t  = e.on_b ? b_tc   : a_tc;
         d  = e.on_b ? b_dir  : a_dir;
         dn = e.on_b ? b_done : a_done;
         n_checks++;
         if ({c, s, t, d, dn} !== {e.cnt, e.seq, e.tc, e.dir, e.done}) begin
            n_fail++;
            $display("FAIL %s [mod%0d]: got cnt=%0d seq=%h tc=%b dir=%b done=%b, required cnt=%0d seq=%h tc=%b dir=%b done=%b",
                     e.name, e.on_b ? 16 : 10, c, s, t, d, dn, e.cnt, e.seq, e.tc, e.dir, e.done);
         end
      end
   end

   task automatic step(input logic rst, input logic load, input logic ce, input logic [3:0] dat,
                       input logic up, input logic [1:0] mode, input logic we = 1'b0,
                       input logic [3:0] addr = 4'd0, input logic [3:0] tdat = 4'd0);
      @(negedge CLK);
      RST = rst; LOAD = load; CE = ce; DAT_I = dat; UP = up; MODE = mode;
      TBL_WE = we; TBL_ADDR = addr; TBL_DAT = tdat;
   endtask

   task automatic expect_out(input bit on_b, input string name, input logic [3:0] cnt,
                             input logic [3:0] seq, input logic tc, input logic dir,
                             input logic done);
      exp_t e;
      e.on_b = on_b; e.name = name; e.cnt = cnt; e.seq = seq;
      e.tc = tc; e.dir = dir; e.done = done;
      sb_q.push_back(e);
   endtask

   initial begin
      // Reset state; bounce mode exposes the internal direction register.
      step(1, 0, 0, 4'd0, 0, MODE_BOUNCE);
      expect_out(0, "reset_a", 4'd0, 4'd0, 0, 1, 0);
      expect_out(1, "reset_b", 4'd0, 4'd0, 0, 1, 0);

      // Wrap up through MOD=10.
      for (int k = 1; k <= 12; k++) begin
         step(0, 0, 1, 4'd0, 1, MODE_WRAP);
         expect_out(0, $sformatf("wrap_up_%0d", k), 4'(k % 10), 4'(k % 10), k == 10, 1, 0);
      end

      // Bounce from 8; UP held low to show DIR comes from the internal register.
      step(0, 1, 0, 4'd8, 1, MODE_BOUNCE);
      expect_out(0, "bounce_load", 4'd8, 4'd8, 0, 1, 0);
      step(0, 0, 1, 4'd0, 0, MODE_BOUNCE);
      expect_out(0, "bounce_1", 4'd9, 4'd9, 0, 1, 0);
      step(0, 0, 1, 4'd0, 0, MODE_BOUNCE);
      expect_out(0, "bounce_2", 4'd8, 4'd8, 1, 0, 0);
      step(0, 0, 1, 4'd0, 0, MODE_BOUNCE);
      expect_out(0, "bounce_3", 4'd7, 4'd7, 0, 0, 0);
      step(0, 0, 1, 4'd0, 0, MODE_BOUNCE);
      expect_out(0, "bounce_4", 4'd6, 4'd6, 0, 0, 0);
      step(0, 0, 1, 4'd0, 0, MODE_BOUNCE);
      expect_out(0, "bounce_5", 4'd5, 4'd5, 0, 0, 0);
      step(0, 0, 1, 4'd0, 0, MODE_WRAP);
      expect_out(0, "mode_switch_wrap_dn", 4'd4, 4'd4, 0, 0, 0);

      // Saturate down.
      step(0, 1, 0, 4'd1, 0, MODE_SAT);
      expect_out(0, "sat_load", 4'd1, 4'd1, 0, 0, 0);
      step(0, 0, 1, 4'd0, 0, MODE_SAT);
      expect_out(0, "sat_1", 4'd0, 4'd0, 0, 0, 0);
      step(0, 0, 1, 4'd0, 0, MODE_SAT);
      expect_out(0, "sat_2", 4'd0, 4'd0, 1, 0, 0);
      step(0, 0, 1, 4'd0, 0, MODE_SAT);
      expect_out(0, "sat_3", 4'd0, 4'd0, 1, 0, 0);
      step(0, 0, 0, 4'd0, 0, MODE_SAT);
      expect_out(0, "sat_idle", 4'd0, 4'd0, 0, 0, 0);

      // One-shot on MOD=16; MOD=10 copy clamps the load.
      step(0, 1, 0, 4'd13, 1, MODE_ONESHOT);
      expect_out(1, "os_load", 4'd13, 4'd13, 0, 1, 0);
      expect_out(0, "os_load_clamp", 4'd9, 4'd9, 0, 1, 0);
      step(0, 0, 1, 4'd0, 1, MODE_ONESHOT);
      expect_out(1, "os_1", 4'd14, 4'd14, 0, 1, 0);
      step(0, 0, 1, 4'd0, 1, MODE_ONESHOT);
      expect_out(1, "os_2_done", 4'd15, 4'd15, 1, 1, 1);
      step(0, 0, 1, 4'd0, 1, MODE_ONESHOT);
      expect_out(1, "os_3_held", 4'd15, 4'd15, 0, 1, 1);
      step(0, 0, 1, 4'd0, 1, MODE_ONESHOT);
      expect_out(1, "os_4_held", 4'd15, 4'd15, 0, 1, 1);
      step(0, 1, 1, 4'd0, 1, MODE_ONESHOT);
      expect_out(1, "os_reload", 4'd0, 4'd0, 0, 1, 0);
      step(0, 0, 1, 4'd0, 1, MODE_ONESHOT);
      expect_out(1, "os_rearmed", 4'd1, 4'd1, 0, 1, 0);

      // Output table writes.
      step(1, 0, 0, 4'd0, 1, MODE_WRAP);
      expect_out(0, "tbl_reset", 4'd0, 4'd0, 0, 1, 0);
      step(0, 1, 0, 4'd3, 1, MODE_WRAP);
      expect_out(0, "tbl_load3", 4'd3, 4'd3, 0, 1, 0);
      step(0, 0, 0, 4'd0, 1, MODE_WRAP, 1, 4'd3, 4'hA);
      expect_out(0, "tbl_write3", 4'd3, 4'hA, 0, 1, 0);
      expect_out(1, "tbl_write3_b", 4'd3, 4'hA, 0, 1, 0);
      step(0, 0, 0, 4'd0, 1, MODE_WRAP, 1, 4'd12, 4'h5);
      expect_out(0, "tbl_oor_write", 4'd3, 4'hA, 0, 1, 0);
      step(0, 1, 0, 4'd12, 1, MODE_WRAP);
      expect_out(0, "tbl_oor_entry9", 4'd9, 4'd9, 0, 1, 0);
      expect_out(1, "tbl_write12_b", 4'd12, 4'h5, 0, 1, 0);
      step(1, 0, 0, 4'd0, 1, MODE_WRAP, 1, 4'd0, 4'hF);
      expect_out(0, "tbl_rst_wins", 4'd0, 4'd0, 0, 1, 0);
      step(0, 1, 0, 4'd3, 1, MODE_WRAP);
      expect_out(0, "tbl_identity_restored", 4'd3, 4'd3, 0, 1, 0);

      // Load clamp and reset priority.
      step(0, 1, 0, 4'd15, 1, MODE_WRAP);
      expect_out(0, "load_clamp", 4'd9, 4'd9, 0, 1, 0);
      step(0, 1, 0, 4'd8, 1, MODE_ONESHOT);
      expect_out(0, "prio_load8", 4'd8, 4'd8, 0, 1, 0);
      step(0, 0, 1, 4'd0, 1, MODE_ONESHOT);
      expect_out(0, "prio_done", 4'd9, 4'd9, 1, 1, 1);
      step(1, 1, 1, 4'd5, 1, MODE_ONESHOT);
      expect_out(0, "prio_rst_load_ce", 4'd0, 4'd0, 0, 1, 0);

      step(0, 0, 0, 4'd0, 1, MODE_WRAP);
      @(negedge CLK);
      n_checks++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending entries, required 0", sb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
